// File: rtl/regex_pc_fifo_pkg.sv
// Shared definitions for the regex PC FIFO: default widths and the stored entry layout.
package regex_pc_fifo_pkg;

    localparam int DEF_PC_WIDTH   = 9;
    localparam int DEF_CC_ID_BITS = 2;
    localparam int DEF_DEPTH_LOG2 = 4;

    // One pending thread: the character slot it belongs to and the PC to run next.
    typedef struct packed {
        logic [DEF_CC_ID_BITS-1:0] cc_id;
        logic [DEF_PC_WIDTH-1:0]   pc;
    } pc_entry_t;

endpackage

// File: rtl/cc_occupancy_counter.sv
// Counts how many FIFO entries currently carry one particular character-slot id.
module cc_occupancy_counter #(
    parameter int CNT_WIDTH = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic nonzero_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Next count: flush clears, a push and a pop of the same slot cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/regex_pc_fifo.sv
// Thread PC FIFO feeding regex_cpu: continuations from the CPU take priority over
// new seeds from the controller. Handshake: a transfer happens on a clock edge where
// valid and ready are both high; ready never depends on the same-side valid.
module regex_pc_fifo
    import regex_pc_fifo_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int CC_ID_BITS = DEF_CC_ID_BITS,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        seed_valid,
    input  logic [PC_WIDTH-1:0]         seed_pc,
    input  logic [CC_ID_BITS-1:0]       seed_cc_id,
    output logic                        seed_ready,
    input  logic                        cont_valid,
    input  logic [PC_WIDTH-1:0]         cont_pc,
    input  logic [CC_ID_BITS-1:0]       cont_cc_id,
    output logic                        cont_ready,
    output logic                        out_valid,
    output logic [PC_WIDTH-1:0]         out_pc,
    output logic [CC_ID_BITS-1:0]       out_cc_id,
    input  logic                        out_ready,
    output logic                        empty,
    output logic [DEPTH_LOG2:0]         count,
    output logic [(1<<CC_ID_BITS)-1:0]  pending_chars
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int NUM_CC = 1 << CC_ID_BITS;
    localparam int EW     = CC_ID_BITS + PC_WIDTH;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic                  full;
    logic                  push_cont, push_seed, push, pop;
    logic [EW-1:0]         wr_entry;
    logic [EW-1:0]         head;
    logic [CC_ID_BITS-1:0] wr_cc_id;

    assign full       = (count_q == FULL_COUNT);
    assign empty      = (count_q == '0);
    assign out_valid  = !empty;
    assign count      = count_q;

    assign cont_ready = !full && !flush;
    assign seed_ready = !full && !cont_valid && !flush;

    assign push_cont  = cont_valid && cont_ready;
    assign push_seed  = seed_valid && seed_ready;
    assign push       = push_cont || push_seed;
    assign pop        = out_valid && out_ready && !flush;

    assign wr_entry   = push_cont ? {cont_cc_id, cont_pc} : {seed_cc_id, seed_pc};
    assign wr_cc_id   = wr_entry[EW-1:PC_WIDTH];
    assign head       = mem_q[rd_ptr_q];
    assign out_pc     = head[PC_WIDTH-1:0];
    assign out_cc_id  = head[EW-1:PC_WIDTH];

    // Pointer and occupancy next-state; flush overrides any transfer this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            if (push && !pop) count_d = count_q + (DEPTH_LOG2+1)'(1);
            if (pop && !push) count_d = count_q - (DEPTH_LOG2+1)'(1);
        end
    end

    // Pointer and count registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    // One occupancy counter per character slot drives its pending bit.
    for (genvar k = 0; k < NUM_CC; k++) begin : g_cc
        cc_occupancy_counter #(
            .CNT_WIDTH (DEPTH_LOG2 + 1)
        ) u_cc_cnt (
            .clk_i     (clk),
            .rst_ni    (rst),
            .flush_i   (flush),
            .inc_i     (push && (wr_cc_id == CC_ID_BITS'(k))),
            .dec_i     (pop && (out_cc_id == CC_ID_BITS'(k))),
            .nonzero_o (pending_chars[k])
        );
    end

endmodule

// File: tb/tb_regex_pc_fifo.sv
// Self-checking bench for regex_pc_fifo: scoreboard queue of expected entries in FIFO order.
module tb_regex_pc_fifo;

  localparam int PCW   = 9;
  localparam int CCB   = 2;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;
  localparam int EW    = PCW + CCB;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            seed_valid = 1'b0;
  logic [PCW-1:0]  seed_pc = '0;
  logic [CCB-1:0]  seed_cc_id = '0;
  logic            seed_ready;
  logic            cont_valid = 1'b0;
  logic [PCW-1:0]  cont_pc = '0;
  logic [CCB-1:0]  cont_cc_id = '0;
  logic            cont_ready;
  logic            out_valid;
  logic [PCW-1:0]  out_pc;
  logic [CCB-1:0]  out_cc_id;
  logic            out_ready = 1'b0;
  logic            empty;
  logic [DL2:0]    count;
  logic [3:0]      pending_chars;

  logic [EW-1:0]   exp_q[$];
  int              n_cmp = 0;
  int              n_fail = 0;

  regex_pc_fifo #(.PC_WIDTH(PCW), .CC_ID_BITS(CCB), .DEPTH_LOG2(DL2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .seed_valid    (seed_valid),
    .seed_pc       (seed_pc),
    .seed_cc_id    (seed_cc_id),
    .seed_ready    (seed_ready),
    .cont_valid    (cont_valid),
    .cont_pc       (cont_pc),
    .cont_cc_id    (cont_cc_id),
    .cont_ready    (cont_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_cc_id     (out_cc_id),
    .out_ready     (out_ready),
    .empty         (empty),
    .count         (count),
    .pending_chars (pending_chars)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference pending mask, derived from the scoreboard contents
  function automatic logic [3:0] model_pending();
    logic [3:0] m;
    m = '0;
    foreach (exp_q[i]) m[exp_q[i][EW-1:PCW]] = 1'b1;
    return m;
  endfunction

  // One clock cycle with the current inputs. Called at posedge+1; returns at posedge+1.
  // The model decides which transfers happen; popped data is compared to the queue head.
  task automatic clk_cycle();
    logic full_m, fire_c, fire_s, do_pop;
    logic [EW-1:0] exp_e;
    #2;
    full_m = (exp_q.size() == DEPTH);
    fire_c = cont_valid && !full_m && !flush;
    fire_s = seed_valid && !full_m && !cont_valid && !flush;
    do_pop = (exp_q.size() != 0) && out_ready && !flush;
    if (do_pop) begin
      exp_e = exp_q[0];
      n_cmp++;
      if ({out_cc_id, out_pc} !== exp_e) begin
        n_fail++;
        $display("FAIL pop_data: got cc=%0d pc=%0d, expected cc=%0d pc=%0d",
                 out_cc_id, out_pc, exp_e[EW-1:PCW], exp_e[PCW-1:0]);
      end
    end
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (fire_c) exp_q.push_back({cont_cc_id, cont_pc});
      else if (fire_s) exp_q.push_back({seed_cc_id, seed_pc});
    end
  endtask

  task automatic idle_inputs();
    seed_valid = 1'b0;
    cont_valid = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic push_cont_n(input int n);
    for (int i = 0; i < n; i++) begin
      cont_valid = 1'b1;
      cont_pc    = PCW'($urandom_range(0, 511));
      cont_cc_id = CCB'($urandom_range(0, 3));
      clk_cycle();
    end
    cont_valid = 1'b0;
  endtask

  // drain with a cycle budget; callers check empty afterwards
  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) clk_cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0 || pending_chars !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b empty=%b count=%0d pending=%b, expected 0 1 0 0000",
               out_valid, empty, count, pending_chars);
    end
    n_cmp++;
    if (seed_ready !== 1'b1 || cont_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: seed_ready=%b cont_ready=%b, expected 1 1", seed_ready, cont_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_seed_drain();
    seed_valid = 1'b1;
    seed_pc    = 9'd5;
    seed_cc_id = 2'd2;
    clk_cycle();
    seed_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 9'd5 || out_cc_id !== 2'd2) begin
      n_fail++;
      $display("FAIL seed_head: valid=%b pc=%0d cc=%0d, expected 1 5 2", out_valid, out_pc, out_cc_id);
    end
    n_cmp++;
    if (count !== 5'd1 || pending_chars !== 4'b0100) begin
      n_fail++;
      $display("FAIL seed_count: count=%0d pending=%b, expected 1 0100", count, pending_chars);
    end
    out_ready = 1'b1;
    clk_cycle();
    out_ready = 1'b0;
    n_cmp++;
    if (empty !== 1'b1 || pending_chars !== 4'd0) begin
      n_fail++;
      $display("FAIL seed_drained: empty=%b pending=%b, expected 1 0000", empty, pending_chars);
    end
  endtask

  task automatic test_contention();
    seed_valid = 1'b1;
    seed_pc    = 9'd7;
    seed_cc_id = 2'd1;
    cont_valid = 1'b1;
    cont_pc    = 9'd9;
    cont_cc_id = 2'd3;
    #1;
    n_cmp++;
    if (seed_ready !== 1'b0 || cont_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL contention_ready: seed_ready=%b cont_ready=%b, expected 0 1", seed_ready, cont_ready);
    end
    clk_cycle();
    cont_valid = 1'b0;
    n_cmp++;
    if (out_pc !== 9'd9 || out_cc_id !== 2'd3 || count !== 5'd1) begin
      n_fail++;
      $display("FAIL contention_first: pc=%0d cc=%0d count=%0d, expected 9 3 1", out_pc, out_cc_id, count);
    end
    clk_cycle();
    seed_valid = 1'b0;
    n_cmp++;
    if (count !== 5'd2 || pending_chars !== 4'b1010) begin
      n_fail++;
      $display("FAIL contention_second: count=%0d pending=%b, expected 2 1010", count, pending_chars);
    end
    drain();
  endtask

  task automatic test_full_wrap();
    push_cont_n(DEPTH);
    seed_valid = 1'b1;
    cont_valid = 1'b1;
    #1;
    n_cmp++;
    if (count !== 5'd16 || cont_ready !== 1'b0 || seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flags: count=%0d cont_ready=%b seed_ready=%b, expected 16 0 0",
               count, cont_ready, seed_ready);
    end
    clk_cycle();
    idle_inputs();
    out_ready = 1'b1;
    clk_cycle();
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (cont_ready !== 1'b1 || count !== 5'd15) begin
      n_fail++;
      $display("FAIL full_pop_ready: cont_ready=%b count=%0d, expected 1 15", cont_ready, count);
    end
    drain();
    n_cmp++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: empty=%b left=%0d, expected 1 0", empty, exp_q.size());
    end
  endtask

  task automatic test_full_pop_push();
    push_cont_n(DEPTH);
    cont_valid = 1'b1;
    cont_pc    = 9'd321;
    cont_cc_id = 2'd0;
    out_ready  = 1'b1;
    clk_cycle();
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 5'd15) begin
      n_fail++;
      $display("FAIL fullpp_15: count=%0d, expected 15", count);
    end
    clk_cycle();
    cont_valid = 1'b0;
    n_cmp++;
    if (count !== 5'd16 || exp_q.size() != DEPTH) begin
      n_fail++;
      $display("FAIL fullpp_16: count=%0d model=%0d, expected 16", count, exp_q.size());
    end
    drain();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_drain: empty=%b, expected 1", empty);
    end
  endtask

  task automatic test_flush();
    push_cont_n(3);
    flush      = 1'b1;
    cont_valid = 1'b1;
    seed_valid = 1'b1;
    cont_pc    = 9'd77;
    #1;
    n_cmp++;
    if (cont_ready !== 1'b0 || seed_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready: cont_ready=%b seed_ready=%b, expected 0 0", cont_ready, seed_ready);
    end
    clk_cycle();
    idle_inputs();
    n_cmp++;
    if (count !== 5'd0 || empty !== 1'b1 || pending_chars !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_clear: count=%0d empty=%b pending=%b, expected 0 1 0000",
               count, empty, pending_chars);
    end
    clk_cycle();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    push_cont_n(3);
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 5'd0 || pending_chars !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: out_valid=%b count=%0d pending=%b, expected 0 0 0000",
               out_valid, count, pending_chars);
    end
    n_cmp++;
    if (seed_ready !== 1'b1 || cont_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: seed_ready=%b cont_ready=%b, expected 1 1", seed_ready, cont_ready);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [3:0] exp_p;
    for (int i = 0; i < 400; i++) begin
      seed_valid = ($urandom_range(0, 1) == 1);
      seed_pc    = PCW'($urandom_range(0, 511));
      seed_cc_id = CCB'($urandom_range(0, 3));
      cont_valid = ($urandom_range(0, 2) == 0);
      cont_pc    = PCW'($urandom_range(0, 511));
      cont_cc_id = CCB'($urandom_range(0, 3));
      out_ready  = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 79) == 0);
      clk_cycle();
      exp_p = model_pending();
      n_cmp++;
      if (pending_chars !== exp_p || count !== 5'(exp_q.size())) begin
        n_fail++;
        $display("FAIL random_state cycle %0d: pending=%b count=%0d, expected %b %0d",
                 i, pending_chars, count, exp_p, exp_q.size());
      end
    end
    idle_inputs();
    drain();
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL random_drain: empty=%b, expected 1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_seed_drain();
    test_contention();
    test_full_wrap();
    test_full_pop_push();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
